// File: rtl/bus_arb_pkg.sv
// Shared state encoding and helpers for the round-robin bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {IDLE, POP, DELIVER} arb_state_t;

    localparam int DST_W = 8;

    // The round-robin pointer moves to the driver after the one just served.
    function automatic logic [3:0] next_rr(input logic [3:0] ptr, input int n);
        if (int'(ptr) + 1 >= n) begin
            return 4'd0;
        end
        return ptr + 4'd1;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_rr_select.sv
// Rotating priority search: the first pending driver at or after rr_ptr, wrapping modulo drvrs.
module rr_select
    import bus_arb_pkg::*;
#(
    parameter int drvrs = 4
) (
    input  logic [drvrs-1:0] pndng,
    input  logic [3:0]       rr_ptr,
    output logic [3:0]       grant,
    output logic             any_req
);

    // Offset k from the pointer maps to driver j either directly or after one wrap.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        for (int k = 0; k < drvrs; k++) begin
            for (int j = 0; j < drvrs; j++) begin
                if (!any_req && pndng[j] &&
                    ((int'(rr_ptr) + k == j) || (int'(rr_ptr) + k == j + drvrs))) begin
                    grant   = 4'(j);
                    any_req = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter/router for the shared packet bus: grant, pop, decode header, push to destination.
// Define BUS_BCAST_EN to deliver headers equal to bcast_id to every driver except the sender.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int               drvrs    = 4,
    parameter int               pckg_sz  = 16,
    parameter logic [DST_W-1:0] bcast_id = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           pndng,
    input  logic [drvrs*pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]           pop,
    output logic [drvrs-1:0]           push,
    output logic [pckg_sz-1:0]         D_push,
    output logic                       busy,
    output logic [3:0]                 grant_id,
    output logic                       err
);

    arb_state_t         state;
    logic [3:0]         rr_ptr;
    logic [3:0]         sel_id;
    logic               any_req;
    logic [pckg_sz-1:0] pkt_reg;
    logic [pckg_sz-1:0] head_pkt;
    logic               granted_pndng;
    logic [DST_W-1:0]   dst;
    logic               unicast_ok;
    logic               dst_bcast;

    rr_select #(.drvrs(drvrs)) u_rr_select (
        .pndng   (pndng),
        .rr_ptr  (rr_ptr),
        .grant   (sel_id),
        .any_req (any_req)
    );

    always_comb begin
        head_pkt      = '0;
        granted_pndng = 1'b0;
        for (int i = 0; i < drvrs; i++) begin
            if (int'(grant_id) == i) begin
                head_pkt      = D_pop[i*pckg_sz +: pckg_sz];
                granted_pndng = pndng[i];
            end
        end
    end

    assign dst        = pkt_reg[pckg_sz-1 -: DST_W];
    assign unicast_ok = (int'(dst) < drvrs) && (dst != DST_W'(grant_id));
    assign dst_bcast  = (dst == bcast_id);

    // A request withdrawn during POP returns to IDLE without moving the pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            pkt_reg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id <= sel_id;
                        state    <= POP;
                    end
                end
                POP: begin
                    if (granted_pndng) begin
                        pkt_reg <= head_pkt;
                        state   <= DELIVER;
                    end else begin
                        state <= IDLE;
                    end
                end
                DELIVER: begin
                    rr_ptr <= next_rr(grant_id, drvrs);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        pop  = '0;
        push = '0;
        err  = 1'b0;
        for (int j = 0; j < drvrs; j++) begin
            if (state == POP && granted_pndng && int'(grant_id) == j) begin
                pop[j] = 1'b1;
            end
`ifdef BUS_BCAST_EN
            if (state == DELIVER && dst_bcast && int'(grant_id) != j) begin
                push[j] = 1'b1;
            end
`endif
            if (state == DELIVER && unicast_ok && int'(dst) == j) begin
                push[j] = 1'b1;
            end
        end
`ifdef BUS_BCAST_EN
        err = (state == DELIVER) && !unicast_ok && !dst_bcast;
`else
        // Broadcast headers are ordinary drops when the feature is absent.
        err = (state == DELIVER) && (!unicast_ok || dst_bcast);
`endif
    end

    assign D_push = pkt_reg;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: bench-owned driver FIFOs, a packet-level reference model compared every cycle,
// and directed scenarios with hand-computed expectations.
module tb_bus_rr_arbiter;

    localparam int DRVRS = 4;
    localparam int PKT   = 16;
`ifdef BUS_BCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    logic                   clk   = 1'b0;
    logic                   reset = 1'b0;
    logic [DRVRS-1:0]       pndng = '0;
    logic [DRVRS*PKT-1:0]   D_pop = '0;
    logic [DRVRS-1:0]       pop;
    logic [DRVRS-1:0]       push;
    logic [PKT-1:0]         D_push;
    logic                   busy;
    logic [3:0]             grant_id;
    logic                   err;

    bus_rr_arbiter #(.drvrs(DRVRS), .pckg_sz(PKT), .bcast_id(8'hFF)) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .busy     (busy),
        .grant_id (grant_id),
        .err      (err)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle        = 0;

    logic [PKT-1:0]   drv_q [DRVRS][$];
    logic [DRVRS-1:0] hold = '0;

    int               pop_log [$];
    logic [DRVRS-1:0] push_log [$];
    logic [PKT-1:0]   data_log [$];
    int               push_cyc [$];
    int               err_cnt = 0;

    int             m_phase = 0;
    int             m_ptr   = 0;
    int             m_gid   = 0;
    logic [PKT-1:0] m_pkt   = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic applyStimulus(input int drv, input logic [PKT-1:0] pkt);
        drv_q[drv].push_back(pkt);
    endtask

    function automatic bit is_set(input logic [DRVRS-1:0] v, input int i);
        return ((v >> i) & DRVRS'(1)) != '0;
    endfunction

    task automatic next_slot();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input int budget);
        bit done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            #1;
            done = !busy && hold == '0;
            for (int i = 0; i < DRVRS; i++) begin
                if (drv_q[i].size() != 0) done = 1'b0;
            end
        end
        if (!done) checkOutput("drain_timeout", 32'd0, 32'd1);
    endtask

    // Reference model: FIFO heads are the bench's own queues; outputs follow the packet-level rules.
    initial begin : monitor
        logic [DRVRS-1:0] pndng_s, pop_s, exp_pop, exp_push;
        logic             rst_s, exp_err, found;
        logic [PKT-1:0]   head_s;
        logic [7:0]       dst;
        int               cand;
        forever begin
            @(negedge clk);
            pndng_s  = pndng;
            pop_s    = pop;
            rst_s    = reset;
            exp_pop  = '0;
            exp_push = '0;
            exp_err  = 1'b0;
            if (rst_s) begin
                m_phase = 0;
                m_ptr   = 0;
                m_gid   = 0;
                m_pkt   = '0;
            end else if (m_phase == 1) begin
                if (is_set(pndng_s, m_gid)) exp_pop = DRVRS'(1) << m_gid;
            end else if (m_phase == 2) begin
                dst = m_pkt[PKT-1 -: 8];
                if (int'(dst) < DRVRS && int'(dst) != m_gid) exp_push = DRVRS'(1) << dst;
                else if (BCAST && dst == 8'hFF) exp_push = ~(DRVRS'(1) << m_gid);
                else exp_err = 1'b1;
            end
            checkOutput("model_pop", 32'(pop), 32'(exp_pop));
            checkOutput("model_push", 32'(push), 32'(exp_push));
            checkOutput("model_err", 32'(err), 32'(exp_err));
            checkOutput("model_D_push", 32'(D_push), 32'(m_pkt));
            checkOutput("model_busy", 32'(busy), 32'(m_phase != 0));
            checkOutput("model_grant_id", 32'(grant_id), 32'(m_gid));
            if (!rst_s) begin
                for (int i = 0; i < DRVRS; i++) begin
                    if (pop_s[i]) pop_log.push_back(i);
                end
                if (push != '0) begin
                    push_log.push_back(push);
                    data_log.push_back(D_push);
                    push_cyc.push_back(cycle);
                end
                if (err) err_cnt++;
            end
            head_s = (drv_q[m_gid].size() > 0) ? drv_q[m_gid][0] : '0;
            @(posedge clk);
            cycle++;
            #1;
            for (int i = 0; i < DRVRS; i++) begin
                if (pop_s[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
            end
            if (!rst_s) begin
                if (m_phase == 0) begin
                    found = 1'b0;
                    for (int k = 0; k < DRVRS; k++) begin
                        cand = (m_ptr + k) % DRVRS;
                        if (!found && is_set(pndng_s, cand)) begin
                            found = 1'b1;
                            m_gid = cand;
                        end
                    end
                    if (found) m_phase = 1;
                end else if (m_phase == 1) begin
                    if (is_set(pndng_s, m_gid)) begin
                        m_pkt   = head_s;
                        m_phase = 2;
                    end else begin
                        m_phase = 0;
                    end
                end else begin
                    m_ptr   = (m_gid + 1) % DRVRS;
                    m_phase = 0;
                end
            end
            #2;
            for (int i = 0; i < DRVRS; i++) begin
                pndng[i] = (drv_q[i].size() > 0) && !hold[i];
                D_pop[i*PKT +: PKT] = (drv_q[i].size() > 0) ? drv_q[i][0] : '0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, tests run %0d", tests_run);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int pb, pp, e0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Single request from driver 2 to driver 1.
        next_slot();
        applyStimulus(2, 16'h0155);
        @(negedge clk); #1;
        checkOutput("t1_idle_pop", 32'(pop), 32'h0);
        checkOutput("t1_idle_busy", 32'(busy), 32'h0);
        @(negedge clk); #1;
        checkOutput("t1_pop", 32'(pop), 32'b0100);
        checkOutput("t1_grant", 32'(grant_id), 32'd2);
        checkOutput("t1_pop_nopush", 32'(push), 32'h0);
        @(negedge clk); #1;
        checkOutput("t1_push", 32'(push), 32'b0010);
        checkOutput("t1_data", 32'(D_push), 32'h0155);
        checkOutput("t1_err", 32'(err), 32'h0);
        @(negedge clk); #1;
        checkOutput("t1_done_busy", 32'(busy), 32'h0);
        checkOutput("t1_data_held", 32'(D_push), 32'h0155);

        // Reset pulse, then all four drivers loaded with five packets each to (src+1)%4.
        next_slot();
        reset = 1'b1;
        #1;
        checkOutput("t2_reset_grant", 32'(grant_id), 32'd0);
        next_slot();
        reset = 1'b0;
        pb = push_log.size();
        pp = pop_log.size();
        next_slot();
        for (int s = 0; s < DRVRS; s++) begin
            for (int k = 0; k < 5; k++) applyStimulus(s, {8'((s + 1) % DRVRS), 8'(s * 16 + k)});
        end
        wait_drain(200);
        checkOutput("t2_push_count", 32'(push_log.size() - pb), 32'd20);
        if (pop_log.size() - pp >= 20) begin
            for (int i = 0; i < 20; i++) checkOutput("t2_grant_order", 32'(pop_log[pp + i]), 32'(i % DRVRS));
        end
        if (push_log.size() - pb >= 20) begin
            for (int i = 1; i < 20; i++) checkOutput("t2_spacing", 32'(push_cyc[pb + i] - push_cyc[pb + i - 1]), 32'd3);
            checkOutput("t2_first_push", 32'(push_log[pb]), 32'b0010);
            checkOutput("t2_first_data", 32'(data_log[pb]), 32'h0100);
            checkOutput("t2_last_data", 32'(data_log[pb + 19]), 32'h0034);
        end

        // Out-of-range and self-addressed headers are dropped but still advance the pointer.
        e0 = err_cnt;
        pb = push_log.size();
        pp = pop_log.size();
        next_slot();
        applyStimulus(0, 16'h0700);
        applyStimulus(1, 16'h0100);
        wait_drain(50);
        checkOutput("t3_err_count", 32'(err_cnt - e0), 32'd2);
        checkOutput("t3_no_push", 32'(push_log.size() - pb), 32'd0);
        next_slot();
        applyStimulus(0, 16'h0122);
        applyStimulus(2, 16'h0333);
        wait_drain(50);
        if (pop_log.size() - pp >= 4) begin
            checkOutput("t3_grant_a", 32'(pop_log[pp]), 32'd0);
            checkOutput("t3_grant_b", 32'(pop_log[pp + 1]), 32'd1);
            checkOutput("t3_grant_c", 32'(pop_log[pp + 2]), 32'd2);
            checkOutput("t3_grant_d", 32'(pop_log[pp + 3]), 32'd0);
        end else checkOutput("t3_pop_count", 32'(pop_log.size() - pp), 32'd4);
        if (push_log.size() - pb >= 2) begin
            checkOutput("t3_push_a", 32'(push_log[pb]), 32'b1000);
            checkOutput("t3_data_a", 32'(data_log[pb]), 32'h0333);
            checkOutput("t3_data_b", 32'(data_log[pb + 1]), 32'h0122);
        end else checkOutput("t3_push_count", 32'(push_log.size() - pb), 32'd2);

        // Broadcast header from driver 3.
        e0 = err_cnt;
        pb = push_log.size();
        next_slot();
        applyStimulus(3, 16'hFFAA);
        wait_drain(50);
`ifdef BUS_BCAST_EN
        checkOutput("t4_bcast_count", 32'(push_log.size() - pb), 32'd1);
        if (push_log.size() > pb) checkOutput("t4_bcast_vec", 32'(push_log[pb]), 32'b0111);
        checkOutput("t4_bcast_err", 32'(err_cnt - e0), 32'd0);
`else
        checkOutput("t4_bcast_nopush", 32'(push_log.size() - pb), 32'd0);
        checkOutput("t4_bcast_err", 32'(err_cnt - e0), 32'd1);
`endif

        // Reset asserted during DELIVER discards the packet and restarts the pointer at 0.
        next_slot();
        applyStimulus(2, 16'h0155);
        next_slot();
        next_slot();
        checkOutput("t5_deliver_push", 32'(push), 32'b0010);
        reset = 1'b1;
        #1;
        checkOutput("t5_rst_push", 32'(push), 32'h0);
        checkOutput("t5_rst_data", 32'(D_push), 32'h0);
        checkOutput("t5_rst_busy", 32'(busy), 32'h0);
        next_slot();
        reset = 1'b0;
        checkOutput("t5_no_replay", 32'(drv_q[2].size()), 32'd0);
        pp = pop_log.size();
        next_slot();
        applyStimulus(3, 16'h0011);
        applyStimulus(0, 16'h0122);
        wait_drain(50);
        if (pop_log.size() - pp >= 2) begin
            checkOutput("t5_first_grant", 32'(pop_log[pp]), 32'd0);
            checkOutput("t5_second_grant", 32'(pop_log[pp + 1]), 32'd3);
        end else checkOutput("t5_pop_count", 32'(pop_log.size() - pp), 32'd2);

        // Driver 1 withdraws its request during POP, then reasserts alongside driver 2.
        pb = push_log.size();
        pp = pop_log.size();
        next_slot();
        applyStimulus(1, 16'h0244);
        next_slot();
        hold[1] = 1'b1;
        @(negedge clk); #1;
        checkOutput("t6_withdraw_pop", 32'(pop), 32'h0);
        checkOutput("t6_withdraw_busy", 32'(busy), 32'h1);
        checkOutput("t6_withdraw_grant", 32'(grant_id), 32'd1);
        next_slot();
        checkOutput("t6_back_idle", 32'(busy), 32'h0);
        hold[1] = 1'b0;
        applyStimulus(2, 16'h0355);
        wait_drain(50);
        if (pop_log.size() - pp >= 2) begin
            checkOutput("t6_regrant", 32'(pop_log[pp]), 32'd1);
            checkOutput("t6_next_grant", 32'(pop_log[pp + 1]), 32'd2);
        end else checkOutput("t6_pop_count", 32'(pop_log.size() - pp), 32'd2);
        if (push_log.size() - pb >= 2) begin
            checkOutput("t6_push_a", 32'(push_log[pb]), 32'b0100);
            checkOutput("t6_data_a", 32'(data_log[pb]), 32'h0244);
            checkOutput("t6_push_b", 32'(push_log[pb + 1]), 32'b1000);
        end else checkOutput("t6_push_count", 32'(push_log.size() - pb), 32'd2);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
